// File: rtl/clock_time_ctrl_if.sv
// Button/strobe inputs and time/display outputs of the clock timekeeping controller.
// master = stimulus side (buttons, tick), slave = clock_time_ctrl.
interface clock_time_ctrl_if;
  logic       tick_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic [5:0] hour_val;
  logic [5:0] min_val;
  logic [5:0] sec_val;
  logic [1:0] edit_mode;
  logic       blank_hour;
  logic       blank_min;
  logic       day_pulse;

  modport master (
    output tick_1hz, mode_btn, inc_btn, dec_btn,
    input  hour_val, min_val, sec_val, edit_mode, blank_hour, blank_min, day_pulse
  );

  modport slave (
    input  tick_1hz, mode_btn, inc_btn, dec_btn,
    output hour_val, min_val, sec_val, edit_mode, blank_hour, blank_min, day_pulse
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Hours/minutes/seconds timekeeping with a RUN / SET_HOUR / SET_MIN edit FSM
// and blink blanking for the field being edited.
module clock_time_ctrl #(
  parameter int BLINK_DIV = 25000000,
  parameter int HOUR_MAX  = 23
) (
  input logic               clk,
  input logic               rst,
  clock_time_ctrl_if.slave  bus
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] SET_HOUR = 2'b01;
  localparam logic [1:0] SET_MIN  = 2'b10;

  localparam int             CNT_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
  localparam logic [5:0]     HOUR_LAST = 6'(HOUR_MAX);

  logic [5:0]       hour_q, min_q, sec_q;
  logic [5:0]       hour_nxt, min_nxt, sec_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic             day_q, day_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             hidden_q, hidden_nxt;
  logic             blank_hour_q, blank_min_q;
  logic             inc_only, dec_only, edit_accepted;

  assign inc_only = bus.inc_btn & ~bus.dec_btn;
  assign dec_only = bus.dec_btn & ~bus.inc_btn;

  always_comb begin
    mode_nxt      = mode_q;
    hour_nxt      = hour_q;
    min_nxt       = min_q;
    sec_nxt       = sec_q;
    day_nxt       = 1'b0;
    edit_accepted = 1'b0;

    // mode_btn outranks edits and ticks; a discarded edit/tick simply has no effect
    if (bus.mode_btn) begin
      case (mode_q)
        RUN:      mode_nxt = SET_HOUR;
        SET_HOUR: mode_nxt = SET_MIN;
        default: begin
          mode_nxt = RUN;
          sec_nxt  = 6'd0;
        end
      endcase
    end else begin
      case (mode_q)
        SET_HOUR: begin
          edit_accepted = inc_only | dec_only;
          if (inc_only)
            hour_nxt = (hour_q == HOUR_LAST) ? 6'd0 : hour_q + 6'd1;
          else if (dec_only)
            hour_nxt = (hour_q == 6'd0) ? HOUR_LAST : hour_q - 6'd1;
        end
        SET_MIN: begin
          edit_accepted = inc_only | dec_only;
          if (inc_only)
            min_nxt = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else if (dec_only)
            min_nxt = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        default: begin
          if (bus.tick_1hz) begin
            if (sec_q == 6'd59) begin
              sec_nxt = 6'd0;
              if (min_q == 6'd59) begin
                min_nxt = 6'd0;
                if (hour_q == HOUR_LAST) begin
                  hour_nxt = 6'd0;
                  day_nxt  = 1'b1;
                end else begin
                  hour_nxt = hour_q + 6'd1;
                end
              end else begin
                min_nxt = min_q + 6'd1;
              end
            end else begin
              sec_nxt = sec_q + 6'd1;
            end
          end
        end
      endcase
    end
  end

  // Restarting the blink on entry or edit makes the new value show immediately
  always_comb begin
    cnt_nxt    = cnt_q;
    hidden_nxt = hidden_q;
    if (mode_nxt == RUN) begin
      cnt_nxt    = '0;
      hidden_nxt = 1'b0;
    end else if (bus.mode_btn || edit_accepted) begin
      cnt_nxt    = '0;
      hidden_nxt = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_nxt    = '0;
      hidden_nxt = ~hidden_q;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q       <= 6'd0;
      min_q        <= 6'd0;
      sec_q        <= 6'd0;
      mode_q       <= RUN;
      day_q        <= 1'b0;
      cnt_q        <= '0;
      hidden_q     <= 1'b0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      hour_q       <= hour_nxt;
      min_q        <= min_nxt;
      sec_q        <= sec_nxt;
      mode_q       <= mode_nxt;
      day_q        <= day_nxt;
      cnt_q        <= cnt_nxt;
      hidden_q     <= hidden_nxt;
      blank_hour_q <= (mode_nxt == SET_HOUR) && hidden_nxt;
      blank_min_q  <= (mode_nxt == SET_MIN) && hidden_nxt;
    end
  end

  assign bus.hour_val   = hour_q;
  assign bus.min_val    = min_q;
  assign bus.sec_val    = sec_q;
  assign bus.edit_mode  = mode_q;
  assign bus.day_pulse  = day_q;
  assign bus.blank_hour = blank_hour_q;
  assign bus.blank_min  = blank_min_q;

endmodule
